// File: rtl/axi4lite_bridge_pkg.sv
// Shared types and helpers for the AXI4-Lite to Bus2Reg bridge.
package axi4lite_bridge_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_ACC,
    ST_RD_RESP,
    ST_WR_RESP
  } bridge_state_t;

  // Each strobe bit becomes eight consecutive bit enables; callers truncate
  // the result to their own data width.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_biten(
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] biten;
    biten = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      biten[i*8 +: 8] = {8{strb[i]}};
    end
    return biten;
  endfunction

endpackage

// File: rtl/axi4lite_ack_timeout.sv
// Regmap acknowledge watchdog: a down-counter loaded on start, expire at
// terminal count. Only instantiated when AXI_BRIDGE_TIMEOUT_EN is defined.
module axi4lite_ack_timeout #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic          armed_q;

  // Load on start so the first access cycle counts as cycle one; expire
  // therefore fires in the TIMEOUT_CYC-th cycle of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (start) begin
      cnt_q   <= LOAD_VAL;
      armed_q <= 1'b1;
    end else if (clear) begin
      armed_q <= 1'b0;
    end else if (armed_q && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = armed_q && (cnt_q == '0);

endmodule

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave to Bus2Reg master bridge with address window decode and
// round-robin read/write arbitration. Optional regmap ack timeout enabled by
// defining AXI_BRIDGE_TIMEOUT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | nothing in flight; arbitrate pending read vs write
// ST_RD_ACC  | bus_req high for a read, waiting for bus_ready
// ST_WR_ACC  | bus_req high for a write, waiting for bus_ready
// ST_RD_RESP | RVALID high, waiting for RREADY
// ST_WR_RESP | BVALID high, waiting for BREADY
module axi4lite_reg_bridge
  import axi4lite_bridge_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN   = 'h1000,
  parameter int                    TIMEOUT_CYC = 256,
  localparam int                   STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  bus_req,
  output logic                  bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic [DATA_WIDTH-1:0] bus_wr_biten,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic                  bus_err
);

  localparam logic [ADDR_WIDTH-1:0] SPAN_MASK = ADDR_SPAN - 1'b1;

  bridge_state_t state_q, state_d;

  logic                  ready_en_q;
  logic                  last_wr_q;
  logic                  ar_full_q, aw_full_q, w_full_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [DATA_WIDTH-1:0] cur_wdata_q, cur_biten_q, rdata_q;
  resp_t                 rresp_q, bresp_q;

  logic                  ar_hs, aw_hs, w_hs;
  logic                  rd_pend, wr_pend;
  logic                  grant_rd, grant_wr;
  logic                  rd_take, wr_take;
  logic                  sel_in_win;
  logic [ADDR_WIDTH-1:0] ar_addr_eff, aw_addr_eff, sel_addr;
  logic [DATA_WIDTH-1:0] w_data_eff;
  logic [STRB_WIDTH-1:0] w_strb_eff;
  logic                  in_acc;
  logic                  timed_out;

  assign s_axi_arready = ready_en_q && !ar_full_q;
  assign s_axi_awready = ready_en_q && !aw_full_q;
  assign s_axi_wready  = ready_en_q && !w_full_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;

  // A handshake in the current cycle counts as pending so an idle bridge
  // starts the access on the very next cycle.
  assign ar_addr_eff = ar_full_q ? ar_addr_q : s_axi_araddr;
  assign aw_addr_eff = aw_full_q ? aw_addr_q : s_axi_awaddr;
  assign w_data_eff  = w_full_q  ? w_data_q  : s_axi_wdata;
  assign w_strb_eff  = w_full_q  ? w_strb_q  : s_axi_wstrb;

  assign rd_pend  = ar_full_q || ar_hs;
  assign wr_pend  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign grant_rd = rd_pend && (!wr_pend || last_wr_q);
  assign grant_wr = wr_pend && (!rd_pend || !last_wr_q);

  // BASE_ADDR is span-aligned, so the window is a match on the upper bits.
  assign sel_addr   = grant_rd ? ar_addr_eff : aw_addr_eff;
  assign sel_in_win = ((sel_addr ^ BASE_ADDR) & ~SPAN_MASK) == '0;

  assign in_acc        = (state_q == ST_RD_ACC) || (state_q == ST_WR_ACC);
  assign bus_req       = in_acc;
  assign bus_req_is_wr = (state_q == ST_WR_ACC);
  assign bus_addr      = cur_addr_q;
  assign bus_wr_data   = cur_wdata_q;
  assign bus_wr_biten  = cur_biten_q;

  assign s_axi_rvalid = (state_q == ST_RD_RESP);
  assign s_axi_bvalid = (state_q == ST_WR_RESP);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_bresp  = bresp_q;

`ifdef AXI_BRIDGE_TIMEOUT_EN
  logic tmo_expire;

  axi4lite_ack_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ack_timeout (
    .clk    (ACLK),
    .rst    (ARESET),
    .start  ((rd_take || wr_take) && sel_in_win),
    .clear  (!in_acc),
    .expire (tmo_expire)
  );

  assign timed_out = in_acc && tmo_expire;
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, including which holding slot is consumed in IDLE.
  always_comb begin
    state_d = state_q;
    rd_take = 1'b0;
    wr_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          rd_take = 1'b1;
          state_d = sel_in_win ? ST_RD_ACC : ST_RD_RESP;
        end else if (grant_wr) begin
          wr_take = 1'b1;
          state_d = sel_in_win ? ST_WR_ACC : ST_WR_RESP;
        end
      end
      ST_RD_ACC:  if (bus_ready || timed_out) state_d = ST_RD_RESP;
      ST_WR_ACC:  if (bus_ready || timed_out) state_d = ST_WR_RESP;
      ST_RD_RESP: if (s_axi_rready) state_d = ST_IDLE;
      ST_WR_RESP: if (s_axi_bready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Per-channel one-deep holding registers; a take in IDLE beats a new
  // handshake on the same channel.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      ar_full_q  <= 1'b0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      ar_addr_q  <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (rd_take)    ar_full_q <= 1'b0;
      else if (ar_hs) ar_full_q <= 1'b1;
      if (wr_take) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_full_q <= 1'b1;
        if (w_hs)  w_full_q  <= 1'b1;
      end
      if (ar_hs) ar_addr_q <= s_axi_araddr;
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
    end
  end

  // Latch the granted access so the bus side stays stable during x_ACC.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cur_addr_q  <= '0;
      cur_wdata_q <= '0;
      cur_biten_q <= '0;
    end else if (rd_take) begin
      cur_addr_q <= ar_addr_eff - BASE_ADDR;
    end else if (wr_take) begin
      cur_addr_q  <= aw_addr_eff - BASE_ADDR;
      cur_wdata_q <= w_data_eff;
      cur_biten_q <= DATA_WIDTH'(strb_to_biten(MAX_STRB_WIDTH'(w_strb_eff)));
    end
  end

  // Response capture and round-robin history.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      bresp_q   <= OKAY;
      last_wr_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_take && !sel_in_win) begin
            rdata_q <= '0;
            rresp_q <= DECERR;
          end else if (wr_take && !sel_in_win) begin
            bresp_q <= DECERR;
          end
        end
        ST_RD_ACC: begin
          if (bus_ready) begin
            rdata_q <= bus_rd_data;
            rresp_q <= bus_err ? SLVERR : OKAY;
          end else if (timed_out) begin
            rdata_q <= '0;
            rresp_q <= SLVERR;
          end
        end
        ST_WR_ACC: begin
          if (bus_ready)      bresp_q <= bus_err ? SLVERR : OKAY;
          else if (timed_out) bresp_q <= SLVERR;
        end
        ST_RD_RESP: if (s_axi_rready) last_wr_q <= 1'b0;
        ST_WR_RESP: if (s_axi_bready) last_wr_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed testbench for axi4lite_reg_bridge. The timeout scenario runs only
// when AXI_BRIDGE_TIMEOUT_EN is defined.
module tb_axi4lite_reg_bridge;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          s_axi_awvalid = 1'b0, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_wvalid = 1'b0, s_axi_wready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_arvalid = 1'b0, s_axi_arready;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_rvalid, s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          bus_req, bus_req_is_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data, bus_wr_biten;
  logic          bus_ready = 1'b0;
  logic [DW-1:0] bus_rd_data = '0;
  logic          bus_err = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4lite_reg_bridge #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .ADDR_SPAN   (SPAN),
    .TIMEOUT_CYC (8)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .bus_req       (bus_req),
    .bus_req_is_wr (bus_req_is_wr),
    .bus_addr      (bus_addr),
    .bus_wr_data   (bus_wr_data),
    .bus_wr_biten  (bus_wr_biten),
    .bus_ready     (bus_ready),
    .bus_rd_data   (bus_rd_data),
    .bus_err       (bus_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    checks++; if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b expected 000", {s_axi_arready, s_axi_awready, s_axi_wready}); end
    checks++; if ({s_axi_rvalid, s_axi_bvalid, bus_req} !== 3'b000) begin errors++; $display("FAIL rst_valid: got %b expected 000", {s_axi_rvalid, s_axi_bvalid, bus_req}); end
    checks++; if ({s_axi_rresp, s_axi_bresp} !== 4'b0000 || s_axi_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp: got %b rdata %h expected 0000 rdata 0", {s_axi_rresp, s_axi_bresp}, s_axi_rdata); end
    ARESET = 1'b0;
    #1;
    checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("FAIL rst_ready_early: got %b expected 0", s_axi_arready); end
    tick();
    checks++; if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b111) begin errors++; $display("FAIL rst_ready_rise: got %b expected 111", {s_axi_arready, s_axi_awready, s_axi_wready}); end
  endtask

  task automatic test_read_basic();
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h4;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if ({bus_req, bus_req_is_wr} !== 2'b10) begin errors++; $display("FAIL rd_req: got %b expected 10", {bus_req, bus_req_is_wr}); end
    checks++; if (bus_addr !== 32'h4) begin errors++; $display("FAIL rd_addr: got %h expected 00000004", bus_addr); end
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 0", s_axi_rvalid); end
    bus_ready = 1'b1; bus_rd_data = 32'hA5A5_0001;
    tick();
    bus_ready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL rd_rvalid: got rvalid %b req %b expected 1 0", s_axi_rvalid, bus_req); end
    checks++; if (s_axi_rdata !== 32'hA5A5_0001 || s_axi_rresp !== 2'b00) begin errors++; $display("FAIL rd_data: got %h/%b expected a5a50001/00", s_axi_rdata, s_axi_rresp); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rd_done: got rvalid %b expected 0", s_axi_rvalid); end
  endtask

  task automatic test_write_w_first();
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'b0101;
    tick();
    s_axi_wvalid = 1'b0;
    checks++; if (s_axi_wready !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL wr_w_held: got wready %b req %b expected 0 0", s_axi_wready, bus_req); end
    tick();
    tick();
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h8;
    tick();
    s_axi_awvalid = 1'b0;
    checks++; if ({bus_req, bus_req_is_wr} !== 2'b11 || bus_addr !== 32'h8) begin errors++; $display("FAIL wr_req: got %b addr %h expected 11 addr 00000008", {bus_req, bus_req_is_wr}, bus_addr); end
    checks++; if (bus_wr_data !== 32'h1234_5678 || bus_wr_biten !== 32'h00FF_00FF) begin errors++; $display("FAIL wr_data: got %h biten %h expected 12345678 biten 00ff00ff", bus_wr_data, bus_wr_biten); end
    checks++; if (s_axi_wready !== 1'b1) begin errors++; $display("FAIL wr_wready_free: got %b expected 1", s_axi_wready); end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got bvalid %b bresp %b expected 1 00", s_axi_bvalid, s_axi_bresp); end
    tick();
    checks++; if (s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL wr_bvalid_hold: got %b expected 1", s_axi_bvalid); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL wr_done: got bvalid %b expected 0", s_axi_bvalid); end
  endtask

  task automatic test_arbitration();
    int n;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) begin
      s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h10;
      s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h20;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hCAFE_0000 + 32'(r); s_axi_wstrb = 4'b1111;
      tick();
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      checks++; if ({bus_req, bus_req_is_wr} !== 2'b10 || bus_addr !== 32'h10) begin errors++; $display("FAIL arb_first_read r%0d: got %b addr %h expected 10 addr 00000010", r, {bus_req, bus_req_is_wr}, bus_addr); end
      checks++; if ({s_axi_awready, s_axi_wready} !== 2'b00) begin errors++; $display("FAIL arb_wr_held r%0d: got %b expected 00", r, {s_axi_awready, s_axi_wready}); end
      bus_ready = 1'b1; bus_rd_data = 32'h1111_0000 + 32'(r);
      tick();
      bus_ready = 1'b0;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      n = 0;
      while (!bus_req && n < 8) begin tick(); n++; end
      checks++; if ({bus_req, bus_req_is_wr} !== 2'b11 || bus_addr !== 32'h20 || bus_wr_data !== 32'hCAFE_0000 + 32'(r)) begin errors++; $display("FAIL arb_then_write r%0d: got %b addr %h data %h expected 11 addr 00000020", r, {bus_req, bus_req_is_wr}, bus_addr, bus_wr_data); end
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin errors++; $display("FAIL arb_bresp r%0d: got %b/%b expected 1/00", r, s_axi_bvalid, s_axi_bresp); end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
    end
  endtask

  task automatic test_errors();
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + SPAN;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (bus_req !== 1'b0 || s_axi_rvalid !== 1'b1) begin errors++; $display("FAIL dec_hi_path: got req %b rvalid %b expected 0 1", bus_req, s_axi_rvalid); end
    checks++; if (s_axi_rresp !== 2'b11 || s_axi_rdata !== 32'h0) begin errors++; $display("FAIL dec_hi_resp: got %b/%h expected 11/00000000", s_axi_rresp, s_axi_rdata); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE - 32'h4;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (bus_req !== 1'b0 || s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b11) begin errors++; $display("FAIL dec_lo: got req %b rvalid %b rresp %b expected 0 1 11", bus_req, s_axi_rvalid, s_axi_rresp); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + SPAN - 32'h4;
    s_axi_wvalid  = 1'b1; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'b1000;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++; if ({bus_req, bus_req_is_wr} !== 2'b11 || bus_addr !== 32'hFFC || bus_wr_biten !== 32'hFF00_0000) begin errors++; $display("FAIL slv_req: got %b addr %h biten %h expected 11 addr 00000ffc biten ff000000", {bus_req, bus_req_is_wr}, bus_addr, bus_wr_biten); end
    bus_ready = 1'b1; bus_err = 1'b1;
    tick();
    bus_ready = 1'b0; bus_err = 1'b0;
    checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b10) begin errors++; $display("FAIL slv_bresp: got %b/%b expected 1/10", s_axi_bvalid, s_axi_bresp); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen_r;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h30;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", bus_req); end
    ARESET = 1'b1;
    tick();
    checks++; if (bus_req !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got req %b rvalid %b arready %b expected 0 0 0", bus_req, s_axi_rvalid, s_axi_arready); end
    ARESET = 1'b0;
    bus_ready = 1'b1; bus_rd_data = 32'h5555_AAAA;
    seen_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_axi_rvalid || bus_req) seen_r = 1'b1;
    end
    bus_ready = 1'b0;
    checks++; if (seen_r !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got activity %b expected 0", seen_r); end
  endtask

  task automatic test_back_to_back();
    int n;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h40;
    tick();
    s_axi_araddr = BASE + 32'h44;
    tick();
    s_axi_arvalid = 1'b0;
    checks++; if (s_axi_arready !== 1'b0 || bus_addr !== 32'h40 || bus_req !== 1'b1) begin errors++; $display("FAIL b2b_skid: got arready %b addr %h req %b expected 0 00000040 1", s_axi_arready, bus_addr, bus_req); end
    bus_ready = 1'b1; bus_rd_data = 32'h0000_0040;
    tick();
    bus_ready = 1'b0;
    s_axi_rready = 1'b1;
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h40) begin errors++; $display("FAIL b2b_first: got %b/%h expected 1/00000040", s_axi_rvalid, s_axi_rdata); end
    tick();
    s_axi_rready = 1'b0;
    n = 0;
    while (!bus_req && n < 8) begin tick(); n++; end
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h44 || s_axi_arready !== 1'b1) begin errors++; $display("FAIL b2b_second: got req %b addr %h arready %b expected 1 00000044 1", bus_req, bus_addr, s_axi_arready); end
    bus_ready = 1'b1; bus_rd_data = 32'h0000_0044;
    tick();
    bus_ready = 1'b0;
    checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h44) begin errors++; $display("FAIL b2b_second_data: got %b/%h expected 1/00000044", s_axi_rvalid, s_axi_rdata); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

`ifdef AXI_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    bit req_drop;
    s_axi_arvalid = 1'b1; s_axi_araddr = BASE + 32'h80;
    tick();
    s_axi_arvalid = 1'b0;
    k = 0;
    req_drop = 1'b0;
    while (!s_axi_rvalid && k < 20) begin
      if (!bus_req) req_drop = 1'b1;
      tick();
      k++;
    end
    checks++; if (k !== 8 || req_drop !== 1'b0) begin errors++; $display("FAIL tmo_latency: got %0d cycles drop %b expected 8 cycles drop 0", k, req_drop); end
    checks++; if (s_axi_rresp !== 2'b10 || s_axi_rdata !== 32'h0 || bus_req !== 1'b0) begin errors++; $display("FAIL tmo_resp: got %b/%h req %b expected 10/00000000 req 0", s_axi_rresp, s_axi_rdata, bus_req); end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_w_first();
    test_arbitration();
    test_errors();
    test_reset_mid();
    test_back_to_back();
`ifdef AXI_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
